// File: rtl/plazer_st_channel_adapter.sv
// Avalon-ST channel adapter: remaps the input channel, drops packets whose mapped
// channel is illegal, and buffers accepted beats in a 2-entry skid buffer.
module plazer_st_channel_adapter #(
   parameter int DATA_W      = 8,
   parameter int IN_CH_W     = 1,
   parameter int OUT_CH_W    = 8,
   parameter int CH_OFFSET   = 0,
   parameter int MAX_CHANNEL = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic                in_startofpacket,
   input  logic                in_endofpacket,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [IN_CH_W-1:0]  in_channel,
   output logic                in_ready,
   input  logic                out_ready,
   output logic                out_valid,
   output logic                out_startofpacket,
   output logic                out_endofpacket,
   output logic [DATA_W-1:0]   out_data,
   output logic [OUT_CH_W-1:0] out_channel,
   output logic [15:0]         drop_count
);

   localparam int ENTRY_W = DATA_W + OUT_CH_W + 2;
   localparam logic [OUT_CH_W:0] OFFSET_C = (OUT_CH_W+1)'(CH_OFFSET);

   typedef enum logic [1:0] {IDLE, PASS, DROP} pkt_state_t;

   pkt_state_t            state, state_next;
   logic [OUT_CH_W-1:0]   chan_reg;
   logic [OUT_CH_W-1:0]   beat_channel;
   logic                  chan_load;
   logic                  forward;
   logic                  drop_inc;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [OUT_CH_W:0]     mapped_sum;
   logic                  legal;
   logic [1:0]            count, count_next;
   logic [ENTRY_W-1:0]    slot0, slot1, new_entry;

   assign accept = in_valid & in_ready;

   // The extra top bit of the sum catches carries out of the output channel width.
   assign mapped_sum = {{(OUT_CH_W+1-IN_CH_W){1'b0}}, in_channel} + OFFSET_C;
   assign legal      = ~mapped_sum[OUT_CH_W] && (32'(mapped_sum) <= $unsigned(32'(MAX_CHANNEL)));

   always_comb begin
      state_next   = state;
      forward      = 1'b0;
      drop_inc     = 1'b0;
      chan_load    = 1'b0;
      beat_channel = chan_reg;
      if (accept) begin
         if (in_startofpacket) begin
            // A new SOP always starts a fresh packet, silently truncating any open one.
            beat_channel = mapped_sum[OUT_CH_W-1:0];
            if (legal) begin
               forward    = 1'b1;
               chan_load  = 1'b1;
               state_next = in_endofpacket ? IDLE : PASS;
            end else begin
               drop_inc   = 1'b1;
               state_next = in_endofpacket ? IDLE : DROP;
            end
         end else begin
            case (state)
               IDLE: drop_inc = 1'b1;
               PASS: begin
                  forward = 1'b1;
                  if (in_endofpacket) state_next = IDLE;
               end
               DROP: if (in_endofpacket) state_next = IDLE;
               default: state_next = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         chan_reg   <= '0;
         drop_count <= '0;
      end else begin
         state <= state_next;
         if (chan_load) chan_reg <= beat_channel;
         if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

   assign push      = accept & forward;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   assign new_entry = {in_startofpacket, in_endofpacket, beat_channel, in_data};

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + 2'd1;
      else if (!push && pop) count_next = count - 2'd1;
   end

   // slot0 is the output register; slot1 catches the beat accepted while the head stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot0    <= '0;
         slot1    <= '0;
         count    <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         count    <= count_next;
         in_ready <= (count_next != 2'd2);
         case (count)
            2'd0: if (push) slot0 <= new_entry;
            2'd1: begin
               if (push && pop) slot0 <= new_entry;
               else if (push)   slot1 <= new_entry;
            end
            default: if (pop) slot0 <= slot1;
         endcase
      end
   end

   assign out_startofpacket = slot0[ENTRY_W-1];
   assign out_endofpacket   = slot0[ENTRY_W-2];
   assign out_channel       = slot0[DATA_W +: OUT_CH_W];
   assign out_data          = slot0[DATA_W-1:0];

endmodule

// File: tb/tb_plazer_st_channel_adapter.sv
// Directed bench for plazer_st_channel_adapter: one default instance and one with
// CH_OFFSET=3/MAX_CHANNEL=3 for the illegal-channel drop case.
module tb_plazer_st_channel_adapter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid, in_startofpacket, in_endofpacket;
   logic [7:0] in_data;
   logic [0:0] in_channel;
   logic       out_ready;

   logic       in_ready, out_valid, out_startofpacket, out_endofpacket;
   logic [7:0] out_data, out_channel;
   logic [15:0] drop_count;

   logic       in_ready_b, out_valid_b, out_startofpacket_b, out_endofpacket_b;
   logic [7:0] out_data_b, out_channel_b;
   logic [15:0] drop_count_b;

   int tests = 0;
   int fails = 0;
   int idx;
   logic took;

   int   exp_head [17] = '{-1, 0, 1, 2, 2, 2, 2, 2, 3, 4, 5, 6, 7, 8, 9, -1, -1};
   logic exp_rdy  [17] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

   always #5 clk = ~clk;

   plazer_st_channel_adapter u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .in_data(in_data), .in_channel(in_channel), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid(out_valid), .out_startofpacket(out_startofpacket),
      .out_endofpacket(out_endofpacket), .out_data(out_data), .out_channel(out_channel),
      .drop_count(drop_count)
   );

   plazer_st_channel_adapter #(.CH_OFFSET(3), .MAX_CHANNEL(3)) u_dut_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .in_data(in_data), .in_channel(in_channel), .in_ready(in_ready_b),
      .out_ready(out_ready), .out_valid(out_valid_b), .out_startofpacket(out_startofpacket_b),
      .out_endofpacket(out_endofpacket_b), .out_data(out_data_b), .out_channel(out_channel_b),
      .drop_count(drop_count_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic v, input logic sop, input logic eop,
                                 input logic [7:0] d, input logic ch, input logic ordy);
      in_valid         = v;
      in_startofpacket = sop;
      in_endofpacket   = eop;
      in_data          = d;
      in_channel       = ch;
      out_ready        = ordy;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();
      tick();
      check_output("rst_in_ready", in_ready, 0);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_out_data", out_data, 0);
      check_output("rst_out_channel", out_channel, 0);
      check_output("rst_sop_eop", {out_startofpacket, out_endofpacket}, 0);
      check_output("rst_drop_count", drop_count, 0);
      reset_n = 1'b1;
      tick();
      check_output("post_rst_in_ready", in_ready, 1);

      // Three-beat packet on channel 1 with out_ready held high
      apply_stimulus(1, 1, 0, 8'hA0, 1, 1);
      tick();
      check_output("pkt3_b0_valid", out_valid, 1);
      check_output("pkt3_b0_data", out_data, 8'hA0);
      check_output("pkt3_b0_chan", out_channel, 8'h01);
      check_output("pkt3_b0_sop_eop", {out_startofpacket, out_endofpacket}, 2'b10);
      apply_stimulus(1, 0, 0, 8'hA1, 1, 1);
      tick();
      check_output("pkt3_b1_data", out_data, 8'hA1);
      check_output("pkt3_b1_chan", out_channel, 8'h01);
      check_output("pkt3_b1_sop_eop", {out_startofpacket, out_endofpacket}, 2'b00);
      apply_stimulus(1, 0, 1, 8'hA2, 1, 1);
      tick();
      check_output("pkt3_b2_data", out_data, 8'hA2);
      check_output("pkt3_b2_sop_eop", {out_startofpacket, out_endofpacket}, 2'b01);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();
      check_output("pkt3_idle_valid", out_valid, 0);
      check_output("pkt3_drop_count", drop_count, 0);

      // Channel toggles mid-packet; output keeps the SOP channel (0)
      apply_stimulus(1, 1, 0, 8'hB0, 0, 1);
      tick();
      check_output("tog_b0_chan", out_channel, 8'h00);
      apply_stimulus(1, 0, 0, 8'hB1, 1, 1);
      tick();
      check_output("tog_b1_data", out_data, 8'hB1);
      check_output("tog_b1_chan", out_channel, 8'h00);
      apply_stimulus(1, 0, 0, 8'hB2, 0, 1);
      tick();
      check_output("tog_b2_chan", out_channel, 8'h00);
      apply_stimulus(1, 0, 1, 8'hB3, 1, 1);
      tick();
      check_output("tog_b3_data", out_data, 8'hB3);
      check_output("tog_b3_chan", out_channel, 8'h00);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();

      // Orphan beat in IDLE, then a single-beat packet
      apply_stimulus(1, 0, 0, 8'hC0, 0, 1);
      tick();
      check_output("orphan_valid", out_valid, 0);
      check_output("orphan_drop_count", drop_count, 1);
      apply_stimulus(1, 1, 1, 8'hC1, 0, 1);
      tick();
      check_output("single_valid", out_valid, 1);
      check_output("single_data", out_data, 8'hC1);
      check_output("single_sop_eop", {out_startofpacket, out_endofpacket}, 2'b11);
      check_output("single_chan", out_channel, 8'h00);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();
      check_output("single_idle_valid", out_valid, 0);
      check_output("single_drop_count", drop_count, 1);

      // SOP arrives while a packet is open: truncated without counting a drop
      apply_stimulus(1, 1, 0, 8'hF0, 0, 1);
      tick();
      check_output("trunc_b0_chan", out_channel, 8'h00);
      apply_stimulus(1, 1, 1, 8'hF1, 1, 1);
      tick();
      check_output("trunc_new_data", out_data, 8'hF1);
      check_output("trunc_new_chan", out_channel, 8'h01);
      check_output("trunc_new_sop_eop", {out_startofpacket, out_endofpacket}, 2'b11);
      check_output("trunc_drop_count", drop_count, 1);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();

      // Ten-beat stream with out_ready low in cycles 3..6
      idx = 0;
      for (int k = 0; k < 17; k++) begin
         check_output($sformatf("stream%0d_valid", k), out_valid, (exp_head[k] >= 0) ? 1 : 0);
         check_output($sformatf("stream%0d_in_ready", k), in_ready, exp_rdy[k]);
         if (exp_head[k] >= 0) begin
            check_output($sformatf("stream%0d_data", k), out_data, 8'(8'h50 + exp_head[k]));
            check_output($sformatf("stream%0d_sop_eop", k), {out_startofpacket, out_endofpacket},
                         {exp_head[k] == 0, exp_head[k] == 9});
         end
         if (idx < 10)
            apply_stimulus(1, idx == 0, idx == 9, 8'(8'h50 + idx), 0, !(k >= 3 && k <= 6));
         else
            apply_stimulus(0, 0, 0, 8'h00, 0, !(k >= 3 && k <= 6));
         took = in_valid && in_ready;
         tick();
         if (took) idx++;
      end
      check_output("stream_beats_accepted", idx, 10);

      // Reset mid-packet with two beats buffered
      apply_stimulus(1, 1, 0, 8'hD0, 0, 0);
      tick();
      check_output("midrst_b0_valid", out_valid, 1);
      apply_stimulus(1, 0, 0, 8'hD1, 0, 0);
      tick();
      check_output("midrst_full_in_ready", in_ready, 0);
      check_output("midrst_full_data", out_data, 8'hD0);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      reset_n = 1'b0;
      #1;
      check_output("midrst_async_valid", out_valid, 0);
      check_output("midrst_async_data", out_data, 0);
      check_output("midrst_async_drop", drop_count, 0);
      check_output("midrst_async_in_ready", in_ready, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check_output("midrst_post_in_ready", in_ready, 1);
      check_output("midrst_post_valid", out_valid, 0);
      apply_stimulus(1, 1, 1, 8'hE0, 1, 1);
      tick();
      check_output("midrst_next_valid", out_valid, 1);
      check_output("midrst_next_data", out_data, 8'hE0);
      check_output("midrst_next_chan", out_channel, 8'h01);
      check_output("midrst_next_sop_eop", {out_startofpacket, out_endofpacket}, 2'b11);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();

      // Offset instance: channel 1 maps to 4 > MAX_CHANNEL 3, whole packet dropped
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check_output("drop_rst_count", drop_count_b, 0);
      for (int b = 0; b < 4; b++) begin
         apply_stimulus(1, b == 0, b == 3, 8'(8'h60 + b), 1, 1);
         tick();
         check_output($sformatf("drop_b%0d_valid", b), out_valid_b, 0);
         check_output($sformatf("drop_b%0d_in_ready", b), in_ready_b, 1);
         check_output($sformatf("drop_b%0d_count", b), drop_count_b, 1);
      end
      apply_stimulus(1, 0, 0, 8'h70, 0, 1);
      tick();
      check_output("drop_then_orphan_count", drop_count_b, 2);
      check_output("drop_then_orphan_valid", out_valid_b, 0);
      apply_stimulus(1, 1, 1, 8'h71, 0, 1);
      tick();
      check_output("drop_legal_valid", out_valid_b, 1);
      check_output("drop_legal_data", out_data_b, 8'h71);
      check_output("drop_legal_chan", out_channel_b, 8'h03);
      apply_stimulus(0, 0, 0, 8'h00, 0, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
